lsu_ctrl: RTL and testbench

//  Load/store unit: initiator side of the data-memory port (addr/wdata/rdata, mem_read, mem_write, mem_size, mem_unsigned).

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_load_align.sv | 41 ++++
 rtl/lsu_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit: access-size encodings, the
//   controller state type and the misalignment predicate.
// ---------------------------------------------------------------------------
package lsu_pkg;

  // Access size encoding, shared by the request side and the memory side.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC_LO = 3'd1,
    ST_ACC_HI = 3'd2,
    ST_STB    = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_t;

  // Only the two low address bits decide alignment, so the helper takes just
  // those and stays independent of the address width.
  function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                         input logic [1:0] size);
    return ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
//   Combinational load-data aligner. Concatenates two memory words {hi,lo},
//   shifts right by the byte offset, keeps 8/16/32 bits and sign- or
//   zero-extends to 32 bits.
// Ports:
//   i_hi       in  32  upper word (0 for single-beat loads)
//   i_lo       in  32  lower word
//   i_offset   in  2   byte offset of the access inside i_lo
//   i_size     in  2   00=byte, 01=half, 10=word
//   i_unsigned in  1   zero-extend when 1 (ignored for words)
//   o_data     out 32  extended result
// ---------------------------------------------------------------------------
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] w_win;

  // Window of 32 bits starting at the addressed byte.
  assign w_win = 32'({i_hi, i_lo} >> {i_offset, 3'b000});

  always_comb begin
    o_data = w_win;
    case (i_size)
      SZ_BYTE: o_data = i_unsigned ? {24'h0, w_win[7:0]}
                                   : {{24{w_win[7]}}, w_win[7:0]};
      SZ_HALF: o_data = i_unsigned ? {16'h0, w_win[15:0]}
                                   : {{16{w_win[15]}}, w_win[15:0]};
      default: o_data = w_win;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//   Load/store unit, initiator side of the data-memory port. Takes one
//   pipeline request at a time, drives the memory port, splits misaligned
//   accesses into aligned beats (loads: two word reads; stores: byte writes)
//   and returns extended load data or an error flag.
// Parameters:
//   MISALIGN_SPLIT  1: split misaligned accesses; 0: reject them with resp_err
//   ADDR_W          byte-address width
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_write/addr/wdata/size/unsigned   request fields
//   resp_valid/resp_ready           response handshake (held until ready)
//   resp_rdata/resp_err             response payload
//   mem_addr/wdata/read/write/size/unsigned   memory port outputs
//   mem_rdata                       combinational memory read data
// ---------------------------------------------------------------------------
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter bit MISALIGN_SPLIT = 1'b1,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  output logic              mem_unsigned,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        r_state;
  lsu_state_t        w_state_next;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_mis;
  logic [1:0]        r_beat;
  logic [31:0]       r_lo;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_req_mis;
  logic              w_req_err;
  logic [ADDR_W-1:0] w_word_addr;
  logic [1:0]        w_last_beat;
  logic [7:0]        w_stb_byte;
  logic [31:0]       w_align_hi;
  logic [31:0]       w_align_lo;
  logic [1:0]        w_align_off;
  logic [31:0]       w_align_data;

  assign w_req_mis = is_misaligned(req_addr[1:0], req_size);
  assign w_req_err = (req_size == SZ_ILL) || (!MISALIGN_SPLIT && w_req_mis);

  assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_last_beat = (r_size == SZ_HALF) ? 2'd1 : 2'd3;
  assign w_stb_byte  = 8'(r_wdata >> {r_beat, 3'b000});

  // Single-beat loads arrive right-aligned from memory (offset 0, hi=0);
  // the second beat of a split load merges with the saved low word.
  assign w_align_hi  = (r_state == ST_ACC_HI) ? mem_rdata : 32'h0;
  assign w_align_lo  = (r_state == ST_ACC_HI) ? r_lo : mem_rdata;
  assign w_align_off = (r_state == ST_ACC_HI) ? r_addr[1:0] : 2'b00;

  lsu_load_align u_align (
    .i_hi       (w_align_hi),
    .i_lo       (w_align_lo),
    .i_offset   (w_align_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_align_data)
  );

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // Next state and memory port. Memory outputs are decoded from the state
  // register alone, so an asynchronous reset drops the strobes immediately.
  always_comb begin
    w_state_next = r_state;
    mem_addr     = '0;
    mem_wdata    = 32'h0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_size     = SZ_BYTE;
    mem_unsigned = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_req_err)                  w_state_next = ST_RESP;
          else if (req_write && w_req_mis) w_state_next = ST_STB;
          else                            w_state_next = ST_ACC_LO;
        end
      end
      ST_ACC_LO: begin
        if (r_mis && !r_write) begin
          mem_addr     = w_word_addr;
          mem_size     = SZ_WORD;
          mem_read     = 1'b1;
          w_state_next = ST_ACC_HI;
        end else begin
          mem_addr     = r_addr;
          mem_size     = r_size;
          mem_unsigned = r_unsigned;
          mem_read     = !r_write;
          mem_write    = r_write;
          mem_wdata    = r_wdata;
          w_state_next = ST_RESP;
        end
      end
      ST_ACC_HI: begin
        mem_addr     = w_word_addr + ADDR_W'(4);
        mem_size     = SZ_WORD;
        mem_read     = 1'b1;
        w_state_next = ST_RESP;
      end
      ST_STB: begin
        mem_addr  = r_addr + ADDR_W'(r_beat);
        mem_size  = SZ_BYTE;
        mem_wdata = {24'h0, w_stb_byte};
        mem_write = 1'b1;
        if (r_beat == w_last_beat) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_mis      <= 1'b0;
      r_beat     <= 2'd0;
      r_lo       <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_mis      <= w_req_mis;
            r_beat     <= 2'd0;
            r_rdata    <= 32'h0;
            r_err      <= w_req_err;
          end
        end
        ST_ACC_LO: begin
          if (!r_write) begin
            if (r_mis) r_lo    <= mem_rdata;
            else       r_rdata <= w_align_data;
          end
        end
        ST_ACC_HI: r_rdata <= w_align_data;
        ST_STB:    r_beat  <= r_beat + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared request fields, per-DUT valid
  logic        req_write, req_unsigned, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_valid0, req_ready0, resp_valid0, resp_err0;
  logic        req_valid1, req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic [31:0] resp_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        mem_read0, mem_write0, mem_unsigned0;
  logic        mem_read1, mem_write1, mem_unsigned1;
  logic [1:0]  mem_size0, mem_size1;

  lsu_ctrl #(.MISALIGN_SPLIT(1'b1), .ADDR_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(resp_valid0),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_read(mem_read0),
    .mem_write(mem_write0), .mem_size(mem_size0), .mem_unsigned(mem_unsigned0),
    .mem_rdata(mem_rdata0));

  lsu_ctrl #(.MISALIGN_SPLIT(1'b0), .ADDR_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(resp_valid1),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_read(mem_read1),
    .mem_write(mem_write1), .mem_size(mem_size1), .mem_unsigned(mem_unsigned1),
    .mem_rdata(mem_rdata1));

  assign mem_rdata1 = 32'h0;

  // byte-addressed memory model: right-aligned, extended read data
  logic [7:0] mem_b [0:255];
  logic [7:0] ma;
  always_comb begin
    ma = mem_addr0[7:0];
    mem_rdata0 = 32'h0;
    case (mem_size0)
      2'b00: mem_rdata0 = mem_unsigned0 ? {24'h0, mem_b[ma]} : {{24{mem_b[ma][7]}}, mem_b[ma]};
      2'b01: mem_rdata0 = mem_unsigned0 ? {16'h0, mem_b[ma+8'd1], mem_b[ma]}
                                        : {{16{mem_b[ma+8'd1][7]}}, mem_b[ma+8'd1], mem_b[ma]};
      2'b10: mem_rdata0 = {mem_b[ma+8'd3], mem_b[ma+8'd2], mem_b[ma+8'd1], mem_b[ma]};
      default: mem_rdata0 = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write0) begin
      mem_b[ma] <= mem_wdata0[7:0];
      if (mem_size0 != 2'b00) mem_b[ma+8'd1] <= mem_wdata0[15:8];
      if (mem_size0 == 2'b10) begin
        mem_b[ma+8'd2] <= mem_wdata0[23:16];
        mem_b[ma+8'd3] <= mem_wdata0[31:24];
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_b[i] <= 8'h00;
    mem_b[8'h20] <= 8'h11; mem_b[8'h21] <= 8'h22; mem_b[8'h22] <= 8'h33; mem_b[8'h23] <= 8'h44;
    mem_b[8'h24] <= 8'h55; mem_b[8'h25] <= 8'h66; mem_b[8'h26] <= 8'h77; mem_b[8'h27] <= 8'h88;
  end

  // scoreboard
  typedef struct {
    int          dut;
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;
  beat_t beats[$];

  int n_vec = 0;
  int n_bad = 0;
  int strobes1 = 0;
  bit lat_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h required %08h", nm, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic rv, input logic [31:0] rd,
                     input logic er, input logic rrdy);
    if (!rv) return;
    if (q.size() == 0 || q[0].dut != d) begin
      n_vec++; n_bad++;
      $display("FAIL unexpected response dut%0d: got rdata %08h err %b required none", d, rd, er);
      return;
    end
    if (!lat_done) begin
      chk({q[0].name, " latency"}, 32'(cyc - q[0].acc), 32'(q[0].lat));
      lat_done = 1'b1;
    end
    chk({q[0].name, " rdata"}, rd, q[0].rdata);
    chk({q[0].name, " err"}, {31'h0, er}, {31'h0, q[0].err});
    chk({q[0].name, " req_ready"}, {31'h0, rrdy}, 32'h0);
    if (resp_ready) begin
      $display("resp %s: rdata=%08h err=%b", q[0].name, rd, er);
      void'(q.pop_front());
      lat_done = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, resp_valid0, resp_rdata0, resp_err0, req_ready0);
      mon(1, resp_valid1, resp_rdata1, resp_err1, req_ready1);
      if (mem_read0 || mem_write0) beats.push_back('{mem_write0, mem_addr0, mem_wdata0});
      if (mem_read1 || mem_write1) strobes1++;
    end
  end

  task automatic issue(input int d, input string nm, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic un,
                       input logic [31:0] erd, input logic eer, input int lat, input bit push);
    int n = 0;
    int acc;
    @(negedge clk);
    beats.delete();
    while (!(d == 0 ? req_ready0 : req_ready1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_vec++; n_bad++;
      $display("FAIL %s accept: got req_ready 0 required 1 within 20 cycles", nm);
      return;
    end
    req_write = wr; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = un;
    if (d == 0) req_valid0 = 1'b1; else req_valid1 = 1'b1;
    acc = cyc;
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    if (push) q.push_back('{d, nm, erd, eer, lat, acc});
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL %s response: got none required one within 40 cycles", nm);
      q.delete();
      lat_done = 1'b0;
    end
  endtask

  task automatic txn(input int d, input string nm, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] sz, input logic un,
                     input logic [31:0] erd, input logic eer, input int lat);
    issue(d, nm, wr, a, wd, sz, un, erd, eer, lat, 1'b1);
    wait_done(nm);
  endtask

  task automatic chk_beats(input string nm, input int n, input logic [31:0] a0, input int step,
                           input logic wr, input logic [31:0] wd);
    chk({nm, " beat count"}, 32'(beats.size()), 32'(n));
    if (beats.size() == n) begin
      for (int k = 0; k < n; k++) begin
        chk({nm, " beat addr"}, beats[k].addr, a0 + 32'(k * step));
        chk({nm, " beat wr"}, {31'h0, beats[k].wr}, {31'h0, wr});
        if (wr) chk({nm, " beat data"}, beats[k].wdata, {24'h0, 8'(wd >> (8 * k))});
      end
    end
  endtask

  initial begin
    resp_ready = 1'b1; req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_size = W; req_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", {31'h0, req_ready0}, 32'h1);
    chk("reset resp_valid", {31'h0, resp_valid0}, 32'h0);
    chk("reset resp_rdata", resp_rdata0, 32'h0);
    chk("reset resp_err", {31'h0, resp_err0}, 32'h0);
    chk("reset mem strobes", {30'h0, mem_read0, mem_write0}, 32'h0);
    chk("reset mem_addr", mem_addr0, 32'h0);
    rst_n = 1'b1;

    // loads against the initial image
    txn(0, "lw 0x20", 1'b0, 32'h20, 32'h0, W, 1'b0, 32'h44332211, 1'b0, 2);
    chk_beats("lw 0x20", 1, 32'h20, 0, 1'b0, 32'h0);
    txn(0, "lh 0x23", 1'b0, 32'h23, 32'h0, H, 1'b0, 32'h00005544, 1'b0, 3);
    chk_beats("lh 0x23", 2, 32'h20, 4, 1'b0, 32'h0);
    txn(0, "lw 0x21", 1'b0, 32'h21, 32'h0, W, 1'b0, 32'h55443322, 1'b0, 3);
    txn(0, "lb 0x27", 1'b0, 32'h27, 32'h0, B, 1'b0, 32'hFFFFFF88, 1'b0, 2);
    txn(0, "lbu 0x27", 1'b0, 32'h27, 32'h0, B, 1'b1, 32'h00000088, 1'b0, 2);
    txn(0, "lhu 0x26", 1'b0, 32'h26, 32'h0, H, 1'b1, 32'h00008877, 1'b0, 2);
    txn(0, "lh 0x26", 1'b0, 32'h26, 32'h0, H, 1'b0, 32'hFFFF8877, 1'b0, 2);
    txn(0, "lw 0x22 unsigned", 1'b0, 32'h22, 32'h0, W, 1'b1, 32'h66554433, 1'b0, 3);
    txn(0, "size11 load", 1'b0, 32'h20, 32'h0, X, 1'b0, 32'h0, 1'b1, 1);
    chk_beats("size11 load", 0, 32'h0, 0, 1'b0, 32'h0);

    // response held off for five cycles
    resp_ready = 1'b0;
    issue(0, "lw 0x24 hold", 1'b0, 32'h24, 32'h0, W, 1'b0, 32'h88776655, 1'b0, 2, 1'b1);
    repeat (6) @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_done("lw 0x24 hold");

    // stores
    txn(0, "sw 0x22", 1'b1, 32'h22, 32'hDDCCBBAA, W, 1'b0, 32'h0, 1'b0, 5);
    chk_beats("sw 0x22", 4, 32'h22, 1, 1'b1, 32'hDDCCBBAA);
    txn(0, "lw 0x20 after", 1'b0, 32'h20, 32'h0, W, 1'b0, 32'hBBAA2211, 1'b0, 2);
    txn(0, "lw 0x24 after", 1'b0, 32'h24, 32'h0, W, 1'b0, 32'h8877DDCC, 1'b0, 2);
    txn(0, "sh 0x31", 1'b1, 32'h31, 32'h00005A3C, H, 1'b0, 32'h0, 1'b0, 3);
    chk_beats("sh 0x31", 2, 32'h31, 1, 1'b1, 32'h00005A3C);
    txn(0, "lw 0x30", 1'b0, 32'h30, 32'h0, W, 1'b0, 32'h005A3C00, 1'b0, 2);
    txn(0, "sw 0x38", 1'b1, 32'h38, 32'hCAFEF00D, W, 1'b0, 32'h0, 1'b0, 2);
    txn(0, "lw 0x38", 1'b0, 32'h38, 32'h0, W, 1'b0, 32'hCAFEF00D, 1'b0, 2);
    txn(0, "size11 store", 1'b1, 32'h40, 32'h12345678, X, 1'b0, 32'h0, 1'b1, 1);
    txn(0, "lw 0x40", 1'b0, 32'h40, 32'h0, W, 1'b0, 32'h0, 1'b0, 2);

    // rejecting variant
    txn(1, "nosplit lh 0x21", 1'b0, 32'h21, 32'h0, H, 1'b0, 32'h0, 1'b1, 1);
    txn(1, "nosplit sw 0x22", 1'b1, 32'h22, 32'h11111111, W, 1'b0, 32'h0, 1'b1, 1);
    txn(1, "nosplit size11", 1'b0, 32'h20, 32'h0, X, 1'b0, 32'h0, 1'b1, 1);
    chk("nosplit strobes", 32'(strobes1), 32'h0);

    // reset during the second byte beat of a split store
    issue(0, "sw 0x29 reset", 1'b1, 32'h29, 32'h11223344, W, 1'b0, 32'h0, 1'b0, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("stb beat1 mem_write", {31'h0, mem_write0}, 32'h1);
    chk("stb beat1 mem_addr", mem_addr0, 32'h2A);
    rst_n = 1'b0;
    #1;
    chk("reset mem_write drop", {31'h0, mem_write0}, 32'h0);
    chk("reset req_ready", {31'h0, req_ready0}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn(0, "lw 0x28 post-reset", 1'b0, 32'h28, 32'h0, W, 1'b0, 32'h00004400, 1'b0, 2);
    txn(0, "lw 0x2C post-reset", 1'b0, 32'h2C, 32'h0, W, 1'b0, 32'h0, 1'b0, 2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
